// File: rtl/mm_wr_burst_sched_if.sv
// AXI4 write-channel bundle (AW/W/B) between the burst scheduler and the memory slave.
interface mm_wr_burst_sched_if #(
  parameter int ASIZE          = 29,
  parameter int BURST_LEN_SIZE = 8,
  parameter int AXI_DSIZE      = 256,
  parameter int IDSIZE         = 4
);
  logic [IDSIZE-1:0]         axi_awid;
  logic [ASIZE-1:0]          axi_awaddr;
  logic [BURST_LEN_SIZE-1:0] axi_awlen;
  logic [2:0]                axi_awsize;
  logic [1:0]                axi_awburst;
  logic                      axi_awlock;
  logic [3:0]                axi_awcache;
  logic [2:0]                axi_awprot;
  logic [3:0]                axi_awqos;
  logic                      axi_awvalid;
  logic                      axi_awready;
  logic [AXI_DSIZE-1:0]      axi_wdata;
  logic [AXI_DSIZE/8-1:0]    axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;
  logic                      axi_bready;
  logic [IDSIZE-1:0]         axi_bid;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    output axi_bready,
    input  axi_bid, axi_bresp, axi_bvalid
  );

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    input  axi_bready,
    output axi_bid, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/mm_wr_burst_sched.sv
// Multi-channel AXI4 write-burst scheduler: round-robin over per-channel FIFOs, tracks
// frame/line progress and sizes bursts against data, line remainder and the 4 KB boundary.
module mm_wr_burst_sched #(
  parameter int CH_NUM         = 2,
  parameter int ASIZE          = 29,
  parameter int BURST_LEN_SIZE = 8,
  parameter int AXI_DSIZE      = 256,
  parameter int IDSIZE         = 4,
  parameter int ID             = 0,
  parameter int MAX_BURST      = 64,
  parameter int CSIZE          = 10
) (
  input  logic                      axi_aclk,
  input  logic                      axi_resetn,
  input  logic [CH_NUM-1:0]         ch_fsync,
  input  logic [CH_NUM*CSIZE-1:0]   ch_count,
  input  logic [CH_NUM*AXI_DSIZE-1:0] ch_rdata,
  output logic [CH_NUM-1:0]         ch_rd_en,
  input  logic [CH_NUM*ASIZE-1:0]   ch_base_addr,
  input  logic [15:0]               line_beats,
  input  logic [ASIZE-1:0]          line_stride,
  input  logic [15:0]               vactive,
  output logic [CH_NUM-1:0]         ch_frame_done,
  output logic [CH_NUM-1:0]         ch_resp_err,
  output logic                      busy,
  mm_wr_burst_sched_if.master       m_axi
);
  localparam int BSHIFT = $clog2(AXI_DSIZE / 8);
  localparam int LW     = BURST_LEN_SIZE + 1;
  localparam int CW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_B} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             sel_q, sel_d, rr_q, rr_d;
  logic [LW-1:0]             len_q, len_d, beat_q, beat_d;
  logic [ASIZE-1:0]          awaddr_q, awaddr_d;
  logic [BURST_LEN_SIZE-1:0] awlen_q, awlen_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic bready_q, bready_d, busy_q, busy_d;
  logic [CH_NUM-1:0] active_q, active_d, fsync_pend_q, fsync_pend_d;
  logic [CH_NUM-1:0] frame_done_q, frame_done_d, resp_err_q, resp_err_d;
  logic [ASIZE-1:0]  line_addr_q [CH_NUM];
  logic [ASIZE-1:0]  line_addr_d [CH_NUM];
  logic [ASIZE-1:0]  cur_addr_q  [CH_NUM];
  logic [ASIZE-1:0]  cur_addr_d  [CH_NUM];
  logic [15:0]       beats_left_q [CH_NUM];
  logic [15:0]       beats_left_d [CH_NUM];
  logic [15:0]       line_cnt_q  [CH_NUM];
  logic [15:0]       line_cnt_d  [CH_NUM];

  logic [12:0]       b4k  [CH_NUM];
  logic [15:0]       wmin [CH_NUM];
  logic [LW-1:0]     want [CH_NUM];
  logic [CH_NUM-1:0] elig;
  logic [CW-1:0]     pick, idx;
  logic              pick_ok, in_burst, fsync_hit;
  logic [15:0]       nbl, nlc;
  logic [ASIZE-1:0]  nline;

  // A channel is eligible only when its FIFO already holds the whole burst.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      b4k[i]  = (13'h1000 - {1'b0, cur_addr_q[i][11:0]}) >> BSHIFT;
      wmin[i] = 16'(MAX_BURST);
      if (beats_left_q[i] < wmin[i]) wmin[i] = beats_left_q[i];
      if (16'(b4k[i]) < wmin[i])     wmin[i] = 16'(b4k[i]);
      want[i] = LW'(wmin[i]);
      elig[i] = active_q[i] && (wmin[i] != 16'd0) &&
                (32'(ch_count[i*CSIZE +: CSIZE]) >= 32'(wmin[i]));
    end
  end

  // Channels receiving fsync this cycle are skipped so ARB never latches a stale address.
  always_comb begin
    pick_ok = 1'b0;
    pick    = rr_q;
    idx     = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      idx = CW'((32'(rr_q) + k) % CH_NUM);
      if (!pick_ok && elig[idx] && !ch_fsync[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    wlast_d      = wlast_q;
    bready_d     = bready_q;
    active_d     = active_q;
    fsync_pend_d = fsync_pend_q;
    frame_done_d = frame_done_q;
    resp_err_d   = resp_err_q;
    line_addr_d  = line_addr_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    line_cnt_d   = line_cnt_q;
    nbl          = '0;
    nlc          = '0;
    nline        = '0;
    fsync_hit    = 1'b0;
    in_burst     = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);

    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (ch_fsync[i]) begin
        if (in_burst && (sel_q == CW'(i))) begin
          fsync_pend_d[i] = 1'b1;
        end else begin
          cur_addr_d[i]   = ch_base_addr[i*ASIZE +: ASIZE];
          line_addr_d[i]  = ch_base_addr[i*ASIZE +: ASIZE];
          beats_left_d[i] = line_beats;
          line_cnt_d[i]   = '0;
          active_d[i]     = 1'b1;
          frame_done_d[i] = 1'b0;
        end
      end
    end

    case (state_q)
      S_IDLE: if (|elig) state_d = S_ARB;
      S_ARB: begin
        if (pick_ok) begin
          sel_d     = pick;
          len_d     = want[pick];
          awlen_d   = BURST_LEN_SIZE'(want[pick] - LW'(1));
          awaddr_d  = cur_addr_q[pick];
          rr_d      = (32'(pick) == CH_NUM - 1) ? '0 : CW'(pick + 1'b1);
          awvalid_d = 1'b1;
          state_d   = S_AW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AW: begin
        if (m_axi.axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (len_q == LW'(1));
          beat_d    = '0;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (m_axi.axi_wready) begin
          if (beat_q == len_q - LW'(1)) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = S_B;
          end else begin
            beat_d  = beat_q + LW'(1);
            wlast_d = (beat_q + LW'(1) == len_q - LW'(1));
          end
        end
      end
      S_B: begin
        if (m_axi.axi_bvalid) begin
          bready_d = 1'b0;
          state_d  = S_IDLE;
          if (m_axi.axi_bresp != 2'b00) resp_err_d[sel_q] = 1'b1;
          nbl                 = beats_left_q[sel_q] - 16'(len_q);
          beats_left_d[sel_q] = nbl;
          cur_addr_d[sel_q]   = cur_addr_q[sel_q] + (ASIZE'(len_q) << BSHIFT);
          if (nbl == 16'd0) begin
            nlc                 = line_cnt_q[sel_q] + 16'd1;
            nline               = line_addr_q[sel_q] + line_stride;
            line_cnt_d[sel_q]   = nlc;
            line_addr_d[sel_q]  = nline;
            cur_addr_d[sel_q]   = nline;
            beats_left_d[sel_q] = line_beats;
            if (nlc == vactive) begin
              active_d[sel_q]     = 1'b0;
              frame_done_d[sel_q] = 1'b1;
            end
          end
          // A frame restart requested during the burst overrides the progress update.
          fsync_hit            = fsync_pend_q[sel_q] | ch_fsync[sel_q];
          fsync_pend_d[sel_q]  = 1'b0;
          if (fsync_hit) begin
            cur_addr_d[sel_q]   = ch_base_addr[32'(sel_q)*ASIZE +: ASIZE];
            line_addr_d[sel_q]  = ch_base_addr[32'(sel_q)*ASIZE +: ASIZE];
            beats_left_d[sel_q] = line_beats;
            line_cnt_d[sel_q]   = '0;
            active_d[sel_q]     = 1'b1;
            frame_done_d[sel_q] = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      rr_q         <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      busy_q       <= 1'b0;
      active_q     <= '0;
      fsync_pend_q <= '0;
      frame_done_q <= '0;
      resp_err_q   <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        line_addr_q[i]  <= '0;
        cur_addr_q[i]   <= '0;
        beats_left_q[i] <= '0;
        line_cnt_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_q         <= rr_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
      busy_q       <= busy_d;
      active_q     <= active_d;
      fsync_pend_q <= fsync_pend_d;
      frame_done_q <= frame_done_d;
      resp_err_q   <= resp_err_d;
      line_addr_q  <= line_addr_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  always_comb begin
    ch_rd_en = '0;
    if (wvalid_q && m_axi.axi_wready) ch_rd_en[sel_q] = 1'b1;
  end

  logic unused_bid;
  assign unused_bid = ^m_axi.axi_bid;

  assign m_axi.axi_awid    = IDSIZE'(ID);
  assign m_axi.axi_awaddr  = awaddr_q;
  assign m_axi.axi_awlen   = awlen_q;
  assign m_axi.axi_awsize  = 3'(BSHIFT);
  assign m_axi.axi_awburst = 2'b01;
  assign m_axi.axi_awlock  = 1'b0;
  assign m_axi.axi_awcache = 4'b0011;
  assign m_axi.axi_awprot  = 3'b000;
  assign m_axi.axi_awqos   = 4'b0000;
  assign m_axi.axi_awvalid = awvalid_q;
  assign m_axi.axi_wdata   = wvalid_q ? ch_rdata[32'(sel_q)*AXI_DSIZE +: AXI_DSIZE] : '0;
  assign m_axi.axi_wstrb   = '1;
  assign m_axi.axi_wlast   = wlast_q;
  assign m_axi.axi_wvalid  = wvalid_q;
  assign m_axi.axi_bready  = bready_q;
  assign ch_frame_done     = frame_done_q;
  assign ch_resp_err       = resp_err_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_mm_wr_burst_sched.sv
// Directed bench for mm_wr_burst_sched: acts as AXI slave and FWFT FIFO source per channel.
module tb_mm_wr_burst_sched;
  localparam int CH_NUM = 2;
  localparam int ASIZE  = 29;
  localparam int BLS    = 8;
  localparam int DW     = 256;
  localparam int IDS    = 4;
  localparam int CS     = 10;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [CH_NUM-1:0]       ch_fsync, ch_rd_en, ch_frame_done, ch_resp_err;
  logic [CH_NUM*CS-1:0]    ch_count;
  logic [CH_NUM*DW-1:0]    ch_rdata;
  logic [CH_NUM*ASIZE-1:0] ch_base_addr;
  logic [15:0]             line_beats, vactive;
  logic [ASIZE-1:0]        line_stride;
  logic                    busy;
  int unsigned pop_cnt [CH_NUM] = '{default: 0};
  int unsigned exp_pop [CH_NUM] = '{default: 0};
  int checks = 0;
  int failures = 0;

  mm_wr_burst_sched_if #(.ASIZE(ASIZE), .BURST_LEN_SIZE(BLS), .AXI_DSIZE(DW), .IDSIZE(IDS)) axi ();

  mm_wr_burst_sched #(
    .CH_NUM(CH_NUM), .ASIZE(ASIZE), .BURST_LEN_SIZE(BLS), .AXI_DSIZE(DW),
    .IDSIZE(IDS), .ID(0), .MAX_BURST(64), .CSIZE(CS)
  ) dut (
    .axi_aclk(clk), .axi_resetn(resetn), .ch_fsync(ch_fsync), .ch_count(ch_count),
    .ch_rdata(ch_rdata), .ch_rd_en(ch_rd_en), .ch_base_addr(ch_base_addr),
    .line_beats(line_beats), .line_stride(line_stride), .vactive(vactive),
    .ch_frame_done(ch_frame_done), .ch_resp_err(ch_resp_err), .busy(busy), .m_axi(axi)
  );

  // FWFT source: each word carries its channel tag and pop index.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++)
      ch_rdata[i*DW +: DW] = {192'd0, 32'(32'hA0 + i), 32'(pop_cnt[i])};
  end

  always @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++)
      if (ch_rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ch_fsync = '0;
    ch_count = '0;
    ch_base_addr = '0;
    axi.axi_awready = 1'b0;
    axi.axi_wready = 1'b0;
    axi.axi_bvalid = 1'b0;
    axi.axi_bresp = 2'b00;
    axi.axi_bid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_ch(input int c, input logic [ASIZE-1:0] base, input int cnt);
    ch_base_addr[c*ASIZE +: ASIZE] = base;
    ch_count[c*CS +: CS] = CS'(cnt);
  endtask

  task automatic pulse_fsync(input logic [CH_NUM-1:0] m);
    ch_fsync = m;
    @(negedge clk);
    ch_fsync = '0;
  endtask

  task automatic burst(input int ch, input logic [ASIZE-1:0] eaddr, input int elen,
                       input int aw_dly, input bit toggle, input logic [1:0] resp,
                       input bit fsync_mid);
    int n;
    int beats;
    int cyc;
    n = 0;
    while (axi.axi_awvalid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("awvalid", axi.axi_awvalid, 1);
    check("awaddr", axi.axi_awaddr, eaddr);
    check("awlen", axi.axi_awlen, elen - 1);
    for (int d = 0; d < aw_dly; d++) begin
      @(negedge clk);
      check("aw_hold_valid", axi.axi_awvalid, 1);
      check("aw_hold_addr", axi.axi_awaddr, eaddr);
      check("aw_hold_len", axi.axi_awlen, elen - 1);
    end
    axi.axi_awready = 1'b1;
    @(negedge clk);
    axi.axi_awready = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < elen && cyc < 1000) begin
      axi.axi_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      ch_fsync = (fsync_mid && cyc == 3) ? CH_NUM'(1 << ch) : '0;
      #1;
      check("wvalid", axi.axi_wvalid, 1);
      check("wlast", axi.axi_wlast, (beats == elen - 1));
      if (axi.axi_wready) begin
        check("rd_en", ch_rd_en, 1 << ch);
        check("wdata", axi.axi_wdata, {192'd0, 32'(32'hA0 + ch), 32'(exp_pop[ch])});
        exp_pop[ch]++;
        beats++;
      end else begin
        check("rd_en_idle", ch_rd_en, 0);
      end
      @(negedge clk);
      cyc++;
    end
    axi.axi_wready = 1'b0;
    ch_fsync = '0;
    check("w_beats", beats, elen);
    check("bready", axi.axi_bready, 1);
    check("wvalid_off", axi.axi_wvalid, 0);
    axi.axi_bresp = resp;
    axi.axi_bvalid = 1'b1;
    @(negedge clk);
    axi.axi_bvalid = 1'b0;
    axi.axi_bresp = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    int n;
    line_beats = 16'd0;
    vactive = 16'd0;
    line_stride = '0;

    // Reset state
    do_reset();
    check("rst_awvalid", axi.axi_awvalid, 0);
    check("rst_wvalid", axi.axi_wvalid, 0);
    check("rst_wlast", axi.axi_wlast, 0);
    check("rst_bready", axi.axi_bready, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", ch_rd_en, 0);
    check("rst_done", ch_frame_done, 0);
    check("rst_err", ch_resp_err, 0);
    check("rst_wstrb", axi.axi_wstrb, {32{1'b1}});
    check("rst_awaddr", axi.axi_awaddr, 0);
    check("rst_awlen", axi.axi_awlen, 0);
    check("rst_wdata", axi.axi_wdata, 0);
    resetn = 1'b1;
    check("awsize", axi.axi_awsize, 5);
    check("awburst", axi.axi_awburst, 1);
    check("awcache", axi.axi_awcache, 3);
    check("awid", axi.axi_awid, 0);

    // Two lines of 100 beats: split at MAX_BURST, stride to next line
    line_beats = 16'd100; vactive = 16'd2; line_stride = 29'h4000;
    set_ch(0, 29'h0, 200);
    pulse_fsync(2'b01);
    burst(0, 29'h0, 64, 0, 0, 2'b00, 0);
    burst(0, 29'h800, 36, 0, 0, 2'b00, 0);
    burst(0, 29'h4000, 64, 0, 0, 2'b00, 0);
    burst(0, 29'h4800, 36, 0, 0, 2'b00, 0);
    check("t1_done", ch_frame_done, 2'b01);
    check("t1_busy", busy, 0);

    // 4 KB split within one line
    do_reset();
    resetn = 1'b1;
    line_beats = 16'd64; vactive = 16'd1;
    set_ch(0, 29'hF00, 200);
    pulse_fsync(2'b01);
    burst(0, 29'hF00, 8, 0, 0, 2'b00, 0);
    burst(0, 29'h1000, 56, 0, 0, 2'b00, 0);
    check("t2_done", ch_frame_done, 2'b01);

    // Round-robin between two channels
    do_reset();
    resetn = 1'b1;
    line_beats = 16'd16; vactive = 16'd2; line_stride = 29'h1000;
    set_ch(0, 29'h10000, 200);
    set_ch(1, 29'h20000, 200);
    pulse_fsync(2'b11);
    burst(0, 29'h10000, 16, 0, 0, 2'b00, 0);
    burst(1, 29'h20000, 16, 0, 0, 2'b00, 0);
    burst(0, 29'h11000, 16, 0, 0, 2'b00, 0);
    burst(1, 29'h21000, 16, 0, 0, 2'b00, 0);
    check("t3_done", ch_frame_done, 2'b11);

    // Insufficient FIFO data holds off the burst
    do_reset();
    resetn = 1'b1;
    line_beats = 16'd64; vactive = 16'd1;
    set_ch(0, 29'h0, 30);
    pulse_fsync(2'b01);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (axi.axi_awvalid || busy) seen++;
    end
    check("t4_no_burst", seen, 0);
    set_ch(0, 29'h0, 64);
    burst(0, 29'h0, 64, 0, 0, 2'b00, 0);
    check("t4_done", ch_frame_done, 2'b01);

    // Backpressure on AW/W and error response stickiness
    do_reset();
    resetn = 1'b1;
    line_beats = 16'd8; vactive = 16'd1;
    set_ch(0, 29'h400, 100);
    pulse_fsync(2'b01);
    burst(0, 29'h400, 8, 5, 1, 2'b10, 0);
    check("t5_err", ch_resp_err, 2'b01);
    check("t5_done", ch_frame_done, 2'b01);
    pulse_fsync(2'b01);
    burst(0, 29'h400, 8, 0, 0, 2'b00, 0);
    check("t5_err_sticky", ch_resp_err, 2'b01);

    // fsync on the selected channel mid-W restarts the frame after the burst
    do_reset();
    resetn = 1'b1;
    line_beats = 16'd32; vactive = 16'd2; line_stride = 29'h1000;
    set_ch(0, 29'h2000, 100);
    pulse_fsync(2'b01);
    burst(0, 29'h2000, 32, 0, 0, 2'b00, 1);
    check("t6_not_done", ch_frame_done, 2'b00);
    burst(0, 29'h2000, 32, 0, 0, 2'b00, 0);
    burst(0, 29'h3000, 32, 0, 0, 2'b00, 0);
    check("t6_done", ch_frame_done, 2'b01);

    // Reset asserted in the middle of W
    pulse_fsync(2'b01);
    n = 0;
    while (axi.axi_awvalid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t7_awvalid", axi.axi_awvalid, 1);
    axi.axi_awready = 1'b1;
    @(negedge clk);
    axi.axi_awready = 1'b0;
    axi.axi_wready = 1'b1;
    repeat (2) @(negedge clk);
    check("t7_pre_wvalid", axi.axi_wvalid, 1);
    axi.axi_wready = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("t7_awvalid_rst", axi.axi_awvalid, 0);
    check("t7_wvalid_rst", axi.axi_wvalid, 0);
    check("t7_wlast_rst", axi.axi_wlast, 0);
    check("t7_bready_rst", axi.axi_bready, 0);
    check("t7_busy_rst", busy, 0);
    check("t7_rd_en_rst", ch_rd_en, 0);
    check("t7_wdata_rst", axi.axi_wdata, 0);
    check("t7_err_rst", ch_resp_err, 0);
    check("t7_done_rst", ch_frame_done, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("t7_idle_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
